div_unit: RTL and testbench

Iterative multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It complements the single-cycle ALU's multiply path. Sits beside the ALU in the execute stage: the decoder raises one one-hot select plus `start`, the pipeline stalls on `busy`, and it writes back `result` on the `done` pulse. Uses a radix-2 restoring algorithm: one quotient bit per clock, with a sign-correction cycle at the end.

---
 rtl/div_pkg.sv | 40 ++++
 rtl/div_if.sv | 31 +++
 rtl/div_step.sv | 27 ++
 rtl/div_unit.sv | 170 +++++++++++++++++
 tb/tb_div_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative RV32M divider.
// Contents: div_state_t (controller states), div_op_t (decoded operation),
// DIV_WIDTH (default operand width), and helpers that decode the one-hot
// select and classify the resulting operation.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } div_op_t;

    // One-hot select to operation. An all-zero select decodes to OP_NONE.
    function automatic div_op_t decode_op(input logic sel_div, input logic sel_divu,
                                          input logic sel_rem, input logic sel_remu);
        div_op_t op;
        op = OP_NONE;
        if (sel_div)       op = OP_DIV;
        else if (sel_divu) op = OP_DIVU;
        else if (sel_rem)  op = OP_REM;
        else if (sel_remu) op = OP_REMU;
        return op;
    endfunction

    function automatic logic op_signed(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the decoder/pipeline and div_unit.
// master: drives start, flush, operands and the one-hot select.
// slave : the divider; drives busy, done, result and zero_flag.
interface div_if #(
    parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             div_sel_div;
    logic             div_sel_divu;
    logic             div_sel_rem;
    logic             div_sel_remu;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero_flag;

    modport master (
        output start, flush, operand_a, operand_b,
               div_sel_div, div_sel_divu, div_sel_rem, div_sel_remu,
        input  busy, done, result, zero_flag
    );

    modport slave (
        input  start, flush, operand_a, operand_b,
               div_sel_div, div_sel_divu, div_sel_rem, div_sel_remu,
        output busy, done, result, zero_flag
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports: rem/quo  current partial remainder and quotient/dividend shift reg
//        dvs      divisor magnitude
//        rem_c/quo_c  values after one shift + trial subtract
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_c,
    output logic [WIDTH-1:0] quo_c
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtract on WIDTH+1 bits; diff[WIDTH] set means it went negative.
    // A restored value is below the divisor, so it always fits WIDTH bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        rem_c   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_c   = {quo[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Ports: clk, rst_n (async active-low), bus (div_if.slave): start, flush,
//        operand_a/b, one-hot select in; busy, done, result, zero_flag out.
// Build option: DIV_SPECIAL_FAST_EN -- divide-by-zero and signed overflow
//        skip CALC/FIX and finish in the cycle after acceptance.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic  clk,
    input logic  rst_n,
    div_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, a_q;
    div_op_t          op_q;
    logic             neg_quo_q, neg_rem_q, bz_q, ovf_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, busy_q, done_q;

    div_op_t          op_c;
    logic             sgn_c, bz_c, ovf_c, accept_c, fast_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic [WIDTH-1:0] step_rem_c, step_quo_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c, fix_res_c;

    function automatic logic [WIDTH-1:0] pick(input div_op_t op,
                                              input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] res;
        res = '0;
        case (op)
            OP_DIV, OP_DIVU: res = q;
            OP_REM, OP_REMU: res = r;
            default:         res = '0;
        endcase
        return res;
    endfunction

    // Operand conditioning at acceptance: magnitudes and special-case flags.
    always_comb begin
        op_c    = decode_op(bus.div_sel_div, bus.div_sel_divu, bus.div_sel_rem, bus.div_sel_remu);
        sgn_c   = op_signed(op_c);
        a_mag_c = (sgn_c && bus.operand_a[WIDTH-1]) ? WIDTH'(-bus.operand_a) : bus.operand_a;
        b_mag_c = (sgn_c && bus.operand_b[WIDTH-1]) ? WIDTH'(-bus.operand_b) : bus.operand_b;
        bz_c    = (bus.operand_b == '0);
        ovf_c   = sgn_c && (bus.operand_a == MIN_NEG) && (bus.operand_b == '1);
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem   (rem_q),
        .quo   (quo_q),
        .dvs   (dvs_q),
        .rem_c (step_rem_c),
        .quo_c (step_quo_c)
    );

    // Sign correction with explicit overrides for the architectural special cases.
    always_comb begin
        quo_fix_c = neg_quo_q ? WIDTH'(-quo_q) : quo_q;
        rem_fix_c = neg_rem_q ? WIDTH'(-rem_q) : rem_q;
        if (bz_q) begin
            quo_fix_c = '1;
            rem_fix_c = a_q;
        end else if (ovf_q) begin
            quo_fix_c = a_q;
            rem_fix_c = '0;
        end
        fix_res_c = pick(op_q, quo_fix_c, rem_fix_c);
    end

`ifdef DIV_SPECIAL_FAST_EN
    logic [WIDTH-1:0] fast_res_c;
    always_comb begin
        fast_c     = bz_c || ovf_c;
        fast_res_c = pick(op_c, bz_c ? '1 : bus.operand_a, bz_c ? bus.operand_a : '0);
    end
`else
    always_comb fast_c = 1'b0;
`endif

    // Next-state logic; flush wins over start in every state.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    accept_c = 1'b1;
                    state_d  = fast_c ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (bus.flush)          state_d = IDLE;
                else if (cnt_q == '0)   state_d = FIX;
            end
            FIX: begin
                state_d = bus.flush ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            a_q       <= '0;
            op_q      <= OP_NONE;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == CALC) || (state_d == FIX);
            done_q  <= (state_d == DONE);
            if (accept_c) begin
                cnt_q     <= CW'(WIDTH - 1);
                rem_q     <= '0;
                quo_q     <= a_mag_c;
                dvs_q     <= b_mag_c;
                a_q       <= bus.operand_a;
                op_q      <= op_c;
                neg_quo_q <= sgn_c && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]) && !bz_c;
                neg_rem_q <= sgn_c && bus.operand_a[WIDTH-1];
                bz_q      <= bz_c;
                ovf_q     <= ovf_c;
`ifdef DIV_SPECIAL_FAST_EN
                if (fast_c) begin
                    result_q <= fast_res_c;
                    zero_q   <= (fast_res_c == '0);
                end
`endif
            end else if (state_q == CALC) begin
                rem_q <= step_rem_c;
                quo_q <= step_quo_c;
                if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            end
            if (state_q == FIX && !bus.flush) begin
                result_q <= fix_res_c;
                zero_q   <= (fix_res_c == '0);
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.zero_flag = zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit plus hand-written sequences for
// flush, asynchronous reset and back-to-back issue.
module tb_div_unit;

    localparam logic [2:0] C_DIV  = 3'd0;
    localparam logic [2:0] C_DIVU = 3'd1;
    localparam logic [2:0] C_REM  = 3'd2;
    localparam logic [2:0] C_REMU = 3'd3;
    localparam logic [2:0] C_NONE = 3'd4;
    localparam int LAT_NORM = 34;
    localparam int LIMIT    = 100;
`ifdef DIV_SPECIAL_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        spec;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Multi-hot selects are illegal when a request is presented.
    always @(posedge clk) begin
        if (bus.start)
            assert ($countones({bus.div_sel_div, bus.div_sel_divu, bus.div_sel_rem, bus.div_sel_remu}) <= 1)
            else $error("multi-hot select with start");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] op);
        bus.div_sel_div  = (op == C_DIV);
        bus.div_sel_divu = (op == C_DIVU);
        bus.div_sel_rem  = (op == C_REM);
        bus.div_sel_remu = (op == C_REMU);
    endtask

    // Present a request before the next rising edge; return just after it (E0 + 1).
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        set_op(op);
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        set_op(C_REMU);
    endtask

    // Count edges from the accepting edge (counted as 1) until done is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (!bus.done && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int dones;
        logic [31:0] prior;

        vecs[0]  = '{C_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{C_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{C_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        vecs[3]  = '{C_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
        vecs[4]  = '{C_REM,  32'd6,          32'd3,          32'd0,          1'b0};
        vecs[5]  = '{C_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[6]  = '{C_REM,  32'd5,          32'd0,          32'd5,          1'b1};
        vecs[7]  = '{C_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[8]  = '{C_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[9]  = '{C_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[10] = '{C_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1};
        vecs[11] = '{C_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
        vecs[12] = '{C_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
        vecs[13] = '{C_DIVU, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  1'b0};
        vecs[14] = '{C_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          1'b0};
        vecs[15] = '{C_NONE, 32'd50,         32'd5,          32'd0,          1'b0};
        vecs[16] = '{C_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          1'b0};
        vecs[17] = '{C_REM,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  1'b0};
        vecs[18] = '{C_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[19] = '{C_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        set_op(C_NONE);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", 32'(bus.zero_flag), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy1", i), 32'(bus.busy), 32'(!(FAST && vecs[i].spec)));
            wait_done(n);
            check($sformatf("v%0d_lat", i), 32'(n), (FAST && vecs[i].spec) ? 32'd1 : 32'(LAT_NORM));
            check($sformatf("v%0d_res", i), bus.result, vecs[i].res);
            check($sformatf("v%0d_zero", i), 32'(bus.zero_flag), 32'(vecs[i].res == 32'd0));
            check($sformatf("v%0d_busy_done", i), 32'(bus.busy), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
        end
        prior = vecs[NV-1].res;

        // Flush in the 10th cycle of a DIVU 100/7.
        launch(C_DIVU, 32'd100, 32'd7);
        repeat (8) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_done", 32'(bus.done), 32'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("flush_no_done", 32'(dones), 32'd0);
        check("flush_result", bus.result, prior);
        check("flush_zero", 32'(bus.zero_flag), 32'(prior == 32'd0));

        // Asynchronous reset mid-CALC after a non-zero result is held.
        launch(C_DIVU, 32'd100, 32'd7);
        wait_done(n);
        check("pre_rst_res", bus.result, 32'd14);
        launch(C_DIVU, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_result", bus.result, 32'd0);
        check("arst_zero", 32'(bus.zero_flag), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: DIVU 9/3, then REMU 9/4 issued in the DONE cycle.
        launch(C_DIVU, 32'd9, 32'd3);
        wait_done(n);
        check("b2b_lat1", 32'(n), 32'(LAT_NORM));
        check("b2b_res1", bus.result, 32'd3);
        set_op(C_REMU);
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd4;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.operand_a = 32'd0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_held", bus.result, 32'd3);
        wait_done(n);
        check("b2b_lat2", 32'(n), 32'(LAT_NORM));
        check("b2b_res2", bus.result, 32'd1);
        check("b2b_zero2", 32'(bus.zero_flag), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
